// File: rtl/if_fetch_if.sv
// Fetch-stage bundle: control from ctrl/ex, the shared byte-wide memory port and the
// {pc, inst, valid} hand-off towards if_id. Signal suffixes are from the fetch stage's
// point of view.
//   master : the fetch stage (drives mem_re_o/mem_a_o/if_*_o)
//   slave  : the surroundings (pipeline control, memory, if_id)
interface if_fetch_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              stall_i;
  logic              branch_flag_i;
  logic [ADDR_W-1:0] branch_target_i;
  logic              mem_re_o;
  logic [ADDR_W-1:0] mem_a_o;
  logic              mem_busy_i;
  logic [7:0]        mem_din_i;
  logic [ADDR_W-1:0] if_pc_o;
  logic [31:0]       if_inst_o;
  logic              if_valid_o;

  modport master (
    input  stall_i, branch_flag_i, branch_target_i, mem_busy_i, mem_din_i,
    output mem_re_o, mem_a_o, if_pc_o, if_inst_o, if_valid_o
  );

  modport slave (
    output stall_i, branch_flag_i, branch_target_i, mem_busy_i, mem_din_i,
    input  mem_re_o, mem_a_o, if_pc_o, if_inst_o, if_valid_o
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage. Owns the PC and builds each 32-bit little-endian instruction
// from four byte reads on the shared memory port, then presents {pc, inst, valid} to if_id.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   fetch_io  : if_fetch_if.master (stall/branch control, memory port, if_id outputs)
module if_fetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic       clk,
  input  logic       rst,
  if_fetch_if.master fetch_io
);

  typedef enum logic [0:0] {StFetch, StValid} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [2:0]        issue_cnt_q;
  logic [2:0]        recv_cnt_q;
  logic              pending_q;
  logic [31:0]       inst_buf_q;
  logic [31:0]       inst_buf_d;
  logic [ADDR_W-1:0] if_pc_q;
  logic [31:0]       if_inst_q;
  logic              if_valid_q;

  logic              mem_re;
  logic              grant;
  logic              unused_tgt_lsb;

  // Redirect targets are word aligned; the low two bits are dropped.
  assign unused_tgt_lsb = ^fetch_io.branch_target_i[1:0];

  always_comb begin
    mem_re = (state_q == StFetch) && (issue_cnt_q < 3'd4) && !rst;
    grant  = mem_re && !fetch_io.mem_busy_i;
  end

  assign fetch_io.mem_re_o   = mem_re;
  assign fetch_io.mem_a_o    = rst ? '0 : pc_q + ADDR_W'(issue_cnt_q);
  assign fetch_io.if_pc_o    = if_pc_q;
  assign fetch_io.if_inst_o  = if_inst_q;
  assign fetch_io.if_valid_o = if_valid_q;

  // Byte returned for the request granted last cycle lands in lane recv_cnt.
  always_comb begin
    inst_buf_d = inst_buf_q;
    unique case (recv_cnt_q[1:0])
      2'd0: inst_buf_d[7:0]   = fetch_io.mem_din_i;
      2'd1: inst_buf_d[15:8]  = fetch_io.mem_din_i;
      2'd2: inst_buf_d[23:16] = fetch_io.mem_din_i;
      2'd3: inst_buf_d[31:24] = fetch_io.mem_din_i;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      pending_q   <= 1'b0;
      inst_buf_q  <= '0;
      if_pc_q     <= '0;
      if_inst_q   <= '0;
      if_valid_q  <= 1'b0;
    end else if (fetch_io.branch_flag_i) begin
      // Redirect wins over everything; a byte still in flight belongs to the old path.
      state_q     <= StFetch;
      pc_q        <= {fetch_io.branch_target_i[ADDR_W-1:2], 2'b00};
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      pending_q   <= 1'b0;
      if_valid_q  <= 1'b0;
      if_inst_q   <= '0;
    end else begin
      case (state_q)
        StFetch: begin
          // An ungranted request is simply repeated at the same address next cycle.
          pending_q <= grant;
          if (grant) begin
            issue_cnt_q <= issue_cnt_q + 3'd1;
          end
          // Capture does not depend on this cycle's busy: the data belongs to last cycle.
          if (pending_q) begin
            inst_buf_q <= inst_buf_d;
            recv_cnt_q <= recv_cnt_q + 3'd1;
            if (recv_cnt_q == 3'd3) begin
              state_q    <= StValid;
              if_inst_q  <= inst_buf_d;
              if_pc_q    <= pc_q;
              if_valid_q <= 1'b1;
            end
          end
        end
        StValid: begin
          if (!fetch_io.stall_i) begin
            state_q     <= StFetch;
            pc_q        <= pc_q + ADDR_W'(4);
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            pending_q   <= 1'b0;
            if_valid_q  <= 1'b0;
            if_inst_q   <= '0;
          end
        end
      endcase
    end
  end

endmodule
